// File: rtl/altair_mem_pkg.sv
// Shared types and defaults for the Altair memory write-path arbiter.
package altair_mem_pkg;
  localparam int          DEF_ADDR_W    = 16;
  localparam logic [15:0] DEF_LOAD_BASE = 16'h0000;
  localparam int          IOCTL_ADDR_W  = 25;

  typedef enum logic [2:0] {
    CPU_OWN,
    HOLD_WAIT,
    LOAD_IDLE,
    LOAD_WRITE,
    RELEASE
  } mem_load_state_t;
endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter bounding how long we wait for the CPU to grant its bus.
module hold_timer #(
  parameter int         W        = 10,
  parameter logic [W-1:0] LOAD_VAL = '1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (load)            cnt <= LOAD_VAL;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/mem_load_arbiter.sv
// Shares the single memory write port between the CPU and the HPS ioctl
// download stream; holds the CPU for the duration of a download.
module mem_load_arbiter
  import altair_mem_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] LOAD_BASE    = ADDR_W'(DEF_LOAD_BASE),
  parameter int                HOLD_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [7:0]              cpu_dout,
  input  logic                    cpu_wr,
  output logic                    cpu_hold,
  input  logic                    cpu_hlda,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_din,
  output logic                    mem_we,
  output logic                    load_active,
  output logic                    load_done,
  output logic [ADDR_W:0]         bytes_loaded,
  output logic                    overflow
);
  localparam int                TMR_W     = $clog2(HOLD_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(HOLD_TIMEOUT - 1);
  localparam logic [ADDR_W:0]   BYTES_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              drop;
  } load_req_t;

  mem_load_state_t state;
  load_req_t       req;
  logic            start;
  logic            tmr_expired;

  assign start = (state == CPU_OWN) && ioctl_download;

  hold_timer #(.W(TMR_W), .LOAD_VAL(TMR_LOAD)) u_hold_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start),
    .en      (state == HOLD_WAIT),
    .clr     ((state != HOLD_WAIT) && !start),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CPU_OWN;
      cpu_hold     <= 1'b0;
      ioctl_wait   <= 1'b0;
      bytes_loaded <= '0;
      overflow     <= 1'b0;
      req          <= '0;
    end else begin
      case (state)
        CPU_OWN: if (ioctl_download) begin
          state        <= HOLD_WAIT;
          cpu_hold     <= 1'b1;
          ioctl_wait   <= 1'b1;
          bytes_loaded <= '0;
          overflow     <= 1'b0;
        end
        // An aborted download takes precedence over a late grant.
        HOLD_WAIT: if (!ioctl_download) begin
          state      <= RELEASE;
          ioctl_wait <= 1'b0;
        end else if (cpu_hlda || tmr_expired) begin
          state      <= LOAD_IDLE;
          ioctl_wait <= 1'b0;
        end
        LOAD_IDLE: if (ioctl_wr) begin
          req.addr   <= LOAD_BASE + ioctl_addr[ADDR_W-1:0];
          req.data   <= ioctl_dout;
          req.drop   <= |ioctl_addr[IOCTL_ADDR_W-1:ADDR_W];
          state      <= LOAD_WRITE;
          ioctl_wait <= 1'b1;
        end else if (!ioctl_download) begin
          state <= RELEASE;
        end
        LOAD_WRITE: begin
          if (req.drop)                       overflow     <= 1'b1;
          else if (bytes_loaded != BYTES_MAX) bytes_loaded <= bytes_loaded + 1'b1;
          state      <= LOAD_IDLE;
          ioctl_wait <= 1'b0;
        end
        RELEASE: begin
          cpu_hold   <= 1'b0;
          ioctl_wait <= 1'b0;
          state      <= CPU_OWN;
        end
        default: state <= CPU_OWN;
      endcase
    end
  end

  // The CPU keeps the port until it has actually been granted away.
  always_comb begin
    mem_addr = req.addr;
    mem_din  = req.data;
    mem_we   = 1'b0;
    case (state)
      CPU_OWN, HOLD_WAIT: begin
        mem_addr = cpu_addr;
        mem_din  = cpu_dout;
        mem_we   = cpu_wr;
      end
      LOAD_WRITE: mem_we = ~req.drop;
      default: ;
    endcase
  end

  assign load_active = (state != CPU_OWN);
  assign load_done   = (state == RELEASE);
endmodule

// File: tb/tb_mem_load_arbiter.sv
// Randomized scoreboard bench for mem_load_arbiter.
module tb_mem_load_arbiter;
  localparam int LB = 0;
  localparam int HT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr = 1'b0, cpu_hold, cpu_hlda = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we, load_active, load_done, overflow;
  logic [16:0] bytes_loaded;

  mem_load_arbiter #(.ADDR_W(16), .LOAD_BASE(16'(LB)), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_hold(cpu_hold),
    .cpu_hlda(cpu_hlda), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .load_active(load_active), .load_done(load_done), .bytes_loaded(bytes_loaded),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vec = 0, errs = 0;
  logic [23:0] exp_q[$];   // {addr, data} of each expected memory write
  logic [17:0] sum_q[$];   // {overflow, bytes_loaded} expected at each load_done
  logic [24:0] b_addr[8];
  logic [7:0]  b_data[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) if (reset_n) begin
    if (mem_we && load_active) begin
      if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_din}, 24'h0);
      else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[23:8]);
        chk("write_data", mem_din, e[7:0]);
      end
    end
    if (load_done) begin
      if (sum_q.size() == 0) chk("unexpected_load_done", 1, 0);
      else begin
        logic [17:0] s;
        s = sum_q.pop_front();
        chk("bytes_loaded", bytes_loaded, s[16:0]);
        chk("overflow", overflow, s[17]);
      end
    end
  end

  // h = cycle index at which the CPU grants hold; 0 means it never does.
  task automatic do_download(input int nb, input int h, input bit simul);
    int n, exp_n, cnt;
    bit ovf;
    int unsigned a;
    cnt = 0; ovf = 0;
    for (int i = 0; i < nb; i++) begin
      if (b_addr[i] < 25'h10000) begin
        a = (LB + b_addr[i]) % 65536;
        exp_q.push_back({a[15:0], b_data[i]});
        cnt++;
      end else ovf = 1;
    end
    sum_q.push_back({ovf, 17'(cnt)});

    @(posedge clk); #1 ioctl_download = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1 n++;
      if (n == 1) begin
        chk("hold_req", cpu_hold, 1);
        chk("wait_on_start", ioctl_wait, 1);
      end
      if (h > 0 && n == h) cpu_hlda = 1'b1;
    end while (ioctl_wait && n < 40);
    exp_n = (h > 0 && h < HT) ? h + 1 : HT + 1;
    chk("hold_latency", n, exp_n);

    for (int i = 0; i < nb; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = b_addr[i]; ioctl_dout = b_data[i];
      if (simul && i == nb - 1) ioctl_download = 1'b0;
      @(posedge clk); #1 ioctl_wr = 1'b0;
      chk("wait_in_write", ioctl_wait, 1);
      @(posedge clk); #1;
      chk("wait_after_write", ioctl_wait, 0);
    end

    ioctl_download = 1'b0;
    n = 0;
    do begin @(posedge clk); #1 n++; end while (!load_done && n < 20);
    chk("release_latency", n, 1);
    chk("hold_in_release", cpu_hold, 1);
    @(posedge clk); #1;
    chk("hold_dropped", cpu_hold, 0);
    chk("single_done", load_done, 0);
    chk("back_to_cpu", load_active, 0);
    chk("bytes_stable", bytes_loaded, 17'(cnt));
    cpu_hlda = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_addr = 16'h5A5A;
    #12;
    chk("rst_hold", cpu_hold, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_done", load_done, 0);
    chk("rst_bytes", bytes_loaded, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_active", load_active, 0);
    chk("rst_pass_addr", mem_addr, 16'h5A5A);
    @(posedge clk); #1 reset_n = 1'b1;

    // CPU passthrough
    cpu_addr = 16'h1234; cpu_dout = 8'hAA; cpu_wr = 1'b1; #1;
    chk("pass_addr", mem_addr, 16'h1234);
    chk("pass_din", mem_din, 8'hAA);
    chk("pass_we", mem_we, 1);
    chk("pass_active", load_active, 0);
    @(posedge clk); #1 cpu_wr = 1'b0;

    // Normal 4-byte load, grant after 3 cycles
    b_addr[0] = 0; b_addr[1] = 1; b_addr[2] = 2; b_addr[3] = 3;
    b_data[0] = 8'h3E; b_data[1] = 8'h01; b_data[2] = 8'hD3; b_data[3] = 8'h10;
    do_download(4, 3, 0);
    // Hold timeout with one byte
    b_addr[0] = 25'h0040; b_data[0] = 8'h77;
    do_download(1, 0, 0);
    // Overflow byte
    b_addr[0] = 25'h10000; b_data[0] = 8'hC3;
    do_download(1, 2, 0);
    // Zero-byte download
    do_download(0, 1, 0);
    // Write and download fall together
    b_addr[0] = 25'h0100; b_addr[1] = 25'h0101; b_data[0] = 8'h11; b_data[1] = 8'h22;
    do_download(2, 4, 1);

    // Randomized downloads
    for (int k = 0; k < 20; k++) begin
      int nb;
      nb = $urandom_range(0, 6);
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(0, 9))
          0: b_addr[i] = 25'h10000 + 25'($urandom_range(0, 32'hFFFF));
          1: b_addr[i] = 25'h1FFFFFF;
          default: b_addr[i] = 25'($urandom_range(0, 32'hFFFF));
        endcase
        b_data[i] = 8'($urandom_range(0, 255));
      end
      do_download(nb, $urandom_range(0, 12), nb > 0 && $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of a byte write
    @(posedge clk); #1 ioctl_download = 1'b1; cpu_hlda = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (!ioctl_wait && cpu_hold) break;
    end
    ioctl_wr = 1'b1; ioctl_addr = 25'h0200; ioctl_dout = 8'h99;
    @(posedge clk); #1 ioctl_wr = 1'b0;
    chk("mid_we_before", mem_we, 1);
    reset_n = 1'b0; #1;
    chk("mid_rst_hold", cpu_hold, 0);
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_done", load_done, 0);
    ioctl_download = 1'b0; cpu_hlda = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_active", load_active, 0);
    chk("post_rst_hold", cpu_hold, 0);
    chk("post_rst_bytes", bytes_loaded, 0);

    repeat (3) @(posedge clk);
    chk("writes_drained", exp_q.size(), 0);
    chk("dones_drained", sum_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
